seq_mult_signed: RTL and testbench

- Parametrised multi-cycle integer multiplier using iterative shift-add on operand magnitudes.
- Supports signed (two's complement) and unsigned modes.
- Result sign is computed as the XOR of the operand signs; the product is negated at the end when that sign is 1.
- Sits in the execute stage beside the ALU; start/done handshake lets the pipeline stall on busy.

---
 rtl/seq_mult_signed.sv | 71 +++++++
 tb/tb_seq_mult_signed.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_signed.sv
// seq_mult_signed: multi-cycle shift-add multiplier on operand magnitudes, signed or unsigned,
// with start/done handshake; result registered WIDTH+1 edges after the start edge.
module seq_mult_signed #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 sign_out
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t               state, state_n;
    logic [2*WIDTH-1:0]   acc, mag_a;
    logic [WIDTH-1:0]     mag_b, abs_a, abs_b;
    logic [CW-1:0]        cnt;
    logic                 sgn;
    always_comb begin
        abs_a   = (signed_mode & a[WIDTH-1]) ? -a : a;
        abs_b   = (signed_mode & b[WIDTH-1]) ? -b : b;
        state_n = state == IDLE ? (start ? RUN : IDLE) :
                  state == RUN  ? (cnt == CW'(1) ? FIX : RUN) : IDLE;
        busy    = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    // mag_a is kept pre-shifted so each iteration adds mag_a << (WIDTH-cnt) without a barrel shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            cnt      <= '0;
            sgn      <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            sign_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sgn   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    mag_a <= {{WIDTH{1'b0}}, abs_a};
                    mag_b <= abs_b;
                    acc   <= '0;
                    cnt   <= CW'(WIDTH);
                end
                RUN: begin
                    if (mag_b[0]) acc <= acc + mag_a;
                    mag_a <= mag_a << 1;
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt - CW'(1);
                end
                FIX: begin
                    product  <= sgn ? -acc : acc;
                    sign_out <= sgn;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_signed.sv
// tb_seq_mult_signed: scoreboard bench for seq_mult_signed at WIDTH 8, 16 and 32.
module tb_seq_mult_signed;
    typedef struct packed {
        logic [127:0] p;
        logic         s;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        st8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, s8;
    logic [15:0] p8;
    logic        st16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, s16;
    logic [31:0] p16;
    logic        st32 = 1'b0, sm32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, s32;
    logic [63:0] p32;

    seq_mult_signed #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(st8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(p8), .sign_out(s8));
    seq_mult_signed #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .start(st16), .signed_mode(sm16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .product(p16), .sign_out(s16));
    seq_mult_signed #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .start(st32), .signed_mode(sm32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .product(p32), .sign_out(s32));

    int   tests = 0, fails = 0;
    exp_t q8[$], q16[$], q32[$];

    // Reference: true integer product of the interpreted operands, truncated to 2w bits
    function automatic exp_t model(input int w, input logic sm, input logic [63:0] a, input logic [63:0] b);
        longint av, bv;
        exp_t   e;
        av = longint'(a);
        bv = longint'(b);
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        e.p = {64'd0, 64'(av * bv)} & ((128'd1 << (2 * w)) - 128'd1);
        e.s = sm & (a[w-1] ^ b[w-1]);
        return e;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] m;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case ($urandom % 8)
            0: return 64'd0;
            1: return 64'd1;
            2: return m;
            3: return 64'd1 << (w - 1);
            4: return m >> 1;
            default: return {32'($urandom), 32'($urandom)} & m;
        endcase
    endfunction

    task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        q8.push_back(model(8, sm, 64'(a), 64'(b)));
        sm8 = sm; a8 = a; b8 = b; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm8;
    endtask

    task automatic wait8(input string name, output int n, output int bc);
        exp_t e;
        n = 0; bc = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy8) bc++;
        end while (!done8 && n < 200);
        tests++;
        if (!done8) begin
            fails++;
            $display("FAIL %s: no done within %0d cycles", name, n);
        end else if (q8.size() == 0) begin
            fails++;
            $display("FAIL %s: done with empty scoreboard, product=%h", name, p8);
        end else begin
            e = q8.pop_front();
            if (p8 !== e.p[15:0] || s8 !== e.s) begin
                fails++;
                $display("FAIL %s: product=%h sign=%b, expected product=%h sign=%b", name, p8, s8, e.p[15:0], e.s);
            end
        end
    endtask

    task automatic op8(input string name, input logic sm, input logic [7:0] a, input logic [7:0] b);
        int n, bc;
        issue8(sm, a, b);
        wait8(name, n, bc);
        tests++;
        if (n !== 10 || bc !== 9) begin
            fails++;
            $display("FAIL %s latency: done at sample %0d busy %0d, expected 10 and 9", name, n, bc);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy8, done8, s8, busy16, done16, s16, busy32, done32, s32} !== 9'd0 || p8 !== '0 || p16 !== '0 || p32 !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%b%b%b done=%b%b%b p8=%h, expected all 0", busy8, busy16, busy32, done8, done16, done32, p8);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        op8("unsigned_max", 1'b0, 8'hFF, 8'hFF);
        tests++;
        if (p8 !== 16'hFE01 || s8 !== 1'b0) begin
            fails++;
            $display("FAIL unsigned_max_const: product=%h sign=%b, expected fe01 0", p8, s8);
        end
        op8("neg3x5", 1'b1, 8'hFD, 8'h05);
        op8("5xneg3", 1'b1, 8'h05, 8'hFD);
        op8("min_x_min", 1'b1, 8'h80, 8'h80);
        op8("min_x_max", 1'b1, 8'h80, 8'h7F);
        op8("neg7x0", 1'b1, 8'hF9, 8'h00);
        op8("unsigned_f9x1", 1'b0, 8'hF9, 8'h01);
    endtask

    task automatic test_ignore_start;
        int n, bc;
        issue8(1'b0, 8'd200, 8'd3);
        repeat (3) @(negedge clk);
        st8 = 1'b1; sm8 = 1'b1; a8 = 8'd17; b8 = 8'hF0;
        @(negedge clk);
        st8 = 1'b0;
        wait8("ignore_start", n, bc);
        tests++;
        if (n !== 6) begin
            fails++;
            $display("FAIL ignore_start latency: done at sample %0d, expected 6", n);
        end
    endtask

    task automatic test_back_to_back;
        int n, bc;
        op8("b2b_first", 1'b1, 8'h9C, 8'h3B);
        issue8(1'b0, 8'd77, 8'd201);
        wait8("b2b_second", n, bc);
        tests++;
        if (n !== 10) begin
            fails++;
            $display("FAIL b2b_spacing: second done %0d cycles after first, expected 10", n);
        end
    endtask

    task automatic test_async_reset;
        logic bad;
        issue8(1'b1, 8'hC3, 8'h5A);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'd0 || s8 !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: busy=%b done=%b product=%h sign=%b, expected 0 0 0000 0", busy8, done8, p8, s8);
        end
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) bad = 1'b1;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: done/busy seen after abort, got %b expected 0", bad);
        end
        op8("after_reset_6x7", 1'b0, 8'd6, 8'd7);
        tests++;
        if (p8 !== 16'd42) begin
            fails++;
            $display("FAIL after_reset_const: product=%0d expected 42", p8);
        end
    endtask

    task automatic test_sweep8;
        int n, bc;
        for (int i = 0; i < 1000; i++) begin
            issue8(1'($urandom), 8'(pick(8)), 8'(pick(8)));
            wait8("sweep8", n, bc);
        end
    endtask

    task automatic test_sweep16;
        exp_t e;
        logic [15:0] a, b;
        logic sm;
        int n;
        for (int i = 0; i < 800; i++) begin
            a = 16'(pick(16)); b = 16'(pick(16)); sm = 1'($urandom);
            q16.push_back(model(16, sm, 64'(a), 64'(b)));
            sm16 = sm; a16 = a; b16 = b; st16 = 1'b1;
            @(posedge clk); #1;
            st16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
            n = 0;
            do begin @(negedge clk); n++; end while (!done16 && n < 200);
            tests++;
            e = q16.pop_front();
            if (!done16 || n !== 18 || p16 !== e.p[31:0] || s16 !== e.s) begin
                fails++;
                $display("FAIL sweep16: a=%h b=%h sm=%b product=%h sign=%b lat=%0d, expected %h %b 18", a, b, sm, p16, s16, n, e.p[31:0], e.s);
            end
        end
    endtask

    task automatic test_sweep32;
        exp_t e;
        logic [31:0] a, b;
        logic sm;
        int n;
        for (int i = 0; i < 600; i++) begin
            a = 32'(pick(32)); b = 32'(pick(32)); sm = 1'($urandom);
            q32.push_back(model(32, sm, 64'(a), 64'(b)));
            sm32 = sm; a32 = a; b32 = b; st32 = 1'b1;
            @(posedge clk); #1;
            st32 = 1'b0; a32 = $urandom; b32 = $urandom;
            n = 0;
            do begin @(negedge clk); n++; end while (!done32 && n < 200);
            tests++;
            e = q32.pop_front();
            if (!done32 || n !== 34 || p32 !== e.p[63:0] || s32 !== e.s) begin
                fails++;
                $display("FAIL sweep32: a=%h b=%h sm=%b product=%h sign=%b lat=%0d, expected %h %b 34", a, b, sm, p32, s32, n, e.p[63:0], e.s);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignore_start;
        test_back_to_back;
        test_async_reset;
        test_sweep8;
        test_sweep16;
        test_sweep32;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
